bird_draw: RTL and testbench

- Downstream stage of the bird physics FSM. Consumes the bird's vertical position once per frame tick and drives the VGA adapter's pixel-write interface.
- Each frame it erases the previously drawn square bird with the background colour, then draws the bird at its new y.
- Sits between the bird control/physics block (inputs bird_y, frame tick) and vga_adapter (outputs x, y, colour, plot) on the 160x120 screen.

---
 rtl/flappy_pkg.sv | 12 +
 rtl/bird_draw_if.sv | 23 ++
 rtl/bird_pixel_scan.sv | 32 +++
 rtl/bird_draw.sv | 139 +++++++++++++
 tb/tb_bird_draw.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/flappy_pkg.sv
// Shared screen, colour and coordinate constants plus the bird draw FSM state type.
package flappy_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int COORD_X_W = 8;
  localparam int COORD_Y_W = 7;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_GREEN = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_ERASE, ST_DRAW, ST_FIN} draw_state_e;
endpackage

// File: rtl/bird_draw_if.sv
// Frame-tick/position input and VGA pixel-write output bundle of the bird drawer.
interface bird_draw_if import flappy_pkg::*; #(
  parameter int X_W = COORD_X_W,
  parameter int Y_W = COORD_Y_W
) ();
  logic           frame_tick;
  logic [Y_W-1:0] bird_y;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [2:0]     colour;
  logic           plot;
  logic           busy;
  logic           done;

  modport master (
    input  frame_tick, bird_y,
    output x_out, y_out, colour, plot, busy, done
  );
  modport slave (
    output frame_tick, bird_y,
    input  x_out, y_out, colour, plot, busy, done
  );
endinterface

// File: rtl/bird_pixel_scan.sv
// Square pixel scan counter: column-major walk over a 2^S x 2^S block.
// dx/dy are the offsets of the count value the next clock edge will hold.
module bird_pixel_scan import flappy_pkg::*; #(
  parameter int SIZE_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  output logic                 last,
  output logic [SIZE_LOG2-1:0] dx,
  output logic [SIZE_LOG2-1:0] dy
);
  localparam int CW = 2 * SIZE_LOG2;

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (start)     cnt_nxt = '0;
    else if (step) cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_nxt;
  end

  assign last = (cnt == '1);
  assign dx   = cnt_nxt[CW-1:SIZE_LOG2];
  assign dy   = cnt_nxt[SIZE_LOG2-1:0];
endmodule

// File: rtl/bird_draw.sv
// Per-frame bird redraw: erase the old square, draw the new one, pulse done.
// Optional BIRD_DRAW_SKIP_UNCHANGED_EN skips the redraw when the position is unchanged.
module bird_draw import flappy_pkg::*; #(
  parameter int         BIRD_X      = 20,
  parameter int         SIZE_LOG2   = 2,
  parameter int         X_W         = COORD_X_W,
  parameter int         Y_W         = COORD_Y_W,
  parameter int         Y_MAX       = 119,
  parameter logic [2:0] BIRD_COLOUR = COL_GREEN,
  parameter logic [2:0] BG_COLOUR   = COL_BLACK
) (
  input  logic       clk,
  input  logic       reset,
  bird_draw_if.master bus
);
  localparam int             SIDE  = 1 << SIZE_LOG2;
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX - SIDE + 1);

  draw_state_e    state, state_n;
  logic [Y_W-1:0] new_y, new_y_n, old_y, old_y_n, y_clamped;
  logic           have_old, have_old_n;
  logic           hold, hold_n;

  logic                 scan_start, scan_step, scan_last;
  logic [SIZE_LOG2-1:0] scan_dx, scan_dy;

  logic [X_W-1:0] x_q, x_n;
  logic [Y_W-1:0] y_q, y_n;
  logic [2:0]     col_q, col_n;
  logic           plot_q, plot_n, busy_q, busy_n, done_q, done_n;

  bird_pixel_scan #(.SIZE_LOG2(SIZE_LOG2)) u_scan (
    .clk   (clk),
    .reset (reset),
    .start (scan_start),
    .step  (scan_step),
    .last  (scan_last),
    .dx    (scan_dx),
    .dy    (scan_dy)
  );

  // Keep the whole square on screen so no row ever wraps.
  assign y_clamped = (bus.bird_y > Y_LIM) ? Y_LIM : bus.bird_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      new_y    <= '0;
      old_y    <= '0;
      have_old <= 1'b0;
      hold     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= BG_COLOUR;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      new_y    <= new_y_n;
      old_y    <= old_y_n;
      have_old <= have_old_n;
      hold     <= hold_n;
      x_q      <= x_n;
      y_q      <= y_n;
      col_q    <= col_n;
      plot_q   <= plot_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    new_y_n    = new_y;
    old_y_n    = old_y;
    have_old_n = have_old;
    hold_n     = hold;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        scan_start = 1'b1;
        if (bus.frame_tick) begin
          new_y_n = y_clamped;
          state_n = have_old ? ST_ERASE : ST_DRAW;
`ifdef BIRD_DRAW_SKIP_UNCHANGED_EN
          // hold stretches FIN by one cycle so done lands two cycles after the tick
          if (have_old && (y_clamped == old_y)) begin
            state_n = ST_FIN;
            hold_n  = 1'b1;
          end
`endif
        end
      end
      ST_ERASE: begin
        scan_step = 1'b1;
        if (scan_last) state_n = ST_DRAW;
      end
      ST_DRAW: begin
        scan_step = 1'b1;
        if (scan_last) state_n = ST_FIN;
      end
      ST_FIN: begin
        if (hold) begin
          hold_n = 1'b0;
        end else begin
          state_n    = ST_IDLE;
          old_y_n    = new_y;
          have_old_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registers line up with it.
  always_comb begin
    x_n    = x_q;
    y_n    = y_q;
    col_n  = col_q;
    plot_n = 1'b0;
    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_FIN) && !hold_n;
    if (state_n == ST_ERASE || state_n == ST_DRAW) begin
      plot_n = 1'b1;
      x_n    = X_W'(BIRD_X) + X_W'(scan_dx);
      y_n    = ((state_n == ST_ERASE) ? old_y : new_y_n) + Y_W'(scan_dy);
      col_n  = (state_n == ST_ERASE) ? BG_COLOUR : BIRD_COLOUR;
    end
  end

  assign bus.x_out  = x_q;
  assign bus.y_out  = y_q;
  assign bus.colour = col_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_bird_draw.sv
// Bench for bird_draw: table of hand-picked frames plus random frames checked
// against a pixel-list model of the erase/draw rules.
module tb_bird_draw;
  localparam int SIDE = 4;
  localparam int NPIX = 16;
  localparam int BX   = 20;
  localparam int YLIM = 116;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int by;
    int x1;
    int x2;
    int rst_at;
    int exp_plots;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;
  int   m_old = 0;
  bit   m_have = 0;

  bird_draw_if #(.X_W(8), .Y_W(7)) bus ();

  bird_draw dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Tick at offset 0, then observe 45 cycles; x1/x2 add extra ticks, rst_at asserts reset.
  task automatic run_frame(input int by, input int x1, input int x2, input int rst_at,
                           output int nplots, output int done_at);
    pix_t exp_q[$];
    pix_t got_q[$];
    int   nb, ndone, busy_end, exp_done, exp_n, yviol;
    bit   skip;
    nb   = (by > YLIM) ? YLIM : by;
    skip = 1'b0;
`ifdef BIRD_DRAW_SKIP_UNCHANGED_EN
    skip = m_have && (nb == m_old);
`endif
    if (!skip) begin
      if (m_have)
        for (int i = 0; i < NPIX; i++)
          exp_q.push_back('{8'(BX + i / SIDE), 7'(m_old + i % SIDE), 3'b000});
      for (int i = 0; i < NPIX; i++)
        exp_q.push_back('{8'(BX + i / SIDE), 7'(nb + i % SIDE), 3'b010});
    end
    exp_done = skip ? 2 : exp_q.size() + 1;
    exp_n    = (rst_at > 0 && rst_at < exp_q.size()) ? rst_at : exp_q.size();

    bus.bird_y     = 7'(by);
    bus.frame_tick = 1'b1;
    done_at = -1; ndone = 0; busy_end = -1; yviol = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (bus.plot) got_q.push_back('{bus.x_out, bus.y_out, bus.colour});
      if (bus.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (!bus.busy && busy_end < 0) busy_end = k;
      if (bus.y_out > 7'd119) yviol++;
      bus.frame_tick = (k == x1) || (k == x2);
      bus.bird_y     = 7'($urandom_range(0, 127));
      reset          = (k == rst_at);
    end

    nplots = got_q.size();
    check("plot_count", nplots, exp_n);
    for (int i = 0; i < exp_n && i < nplots; i++)
      check($sformatf("pixel[%0d] xyc", i), int'(got_q[i]), int'(exp_q[i]));
    check("y_bound", yviol, 0);
    if (rst_at > 0) begin
      check("done_count", ndone, 0);
      check("busy_after_reset", busy_end, rst_at + 1);
      m_have = 1'b0;
    end else begin
      check("done_count", ndone, 1);
      check("done_cycle", done_at, exp_done);
      check("idle_cycle", busy_end, exp_done + 1);
      m_old  = nb;
      m_have = 1'b1;
    end
  endtask

  initial begin
    vec_t tbl[$];
    int   np, dn;

    tbl.push_back('{50,  0,  0,  0, 16, 17});  // first frame: draw only
    tbl.push_back('{46,  0,  0,  0, 32, 33});  // erase 50..53 then draw 46..49
    tbl.push_back('{127, 0,  0,  0, 32, 33});  // clamps to 116
    tbl.push_back('{80,  5, 33,  0, 32, 33});  // ticks while busy / in FIN ignored
    tbl.push_back('{30,  0,  0, 10, 10, -1});  // reset mid-erase
    tbl.push_back('{60,  0,  0,  0, 16, 17});  // draw-only after reset
`ifdef BIRD_DRAW_SKIP_UNCHANGED_EN
    tbl.push_back('{60,  0,  0,  0,  0,  2});
`else
    tbl.push_back('{60,  0,  0,  0, 32, 33});
`endif

    reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.bird_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_x", int'(bus.x_out), 0);
    check("rst_y", int'(bus.y_out), 0);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_plot", int'(bus.plot), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);

    foreach (tbl[i]) begin
      run_frame(tbl[i].by, tbl[i].x1, tbl[i].x2, tbl[i].rst_at, np, dn);
      check($sformatf("tbl[%0d] plots", i), np, tbl[i].exp_plots);
      check($sformatf("tbl[%0d] done", i), dn, tbl[i].exp_done);
    end

    for (int r = 0; r < 10; r++)
      run_frame(int'($urandom_range(0, 127)), 0, 0, 0, np, dn);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
